in_channel_source: RTL and testbench
====================================

IN_CHANNEL_SOURCE -- requirements
Module: in_channel_source

Interface
REQ-001 SHALL have parameter MemoryElementWidth, default 12, the width of one channel word.
REQ-002 SHALL have parameter NIn, default 8, the channel capacity in words (minimum 1).
REQ-003 SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port load_valid, input, 1, host offers load_data.
REQ-006 SHALL have port load_data, input, MemoryElementWidth, word to append.
REQ-007 SHALL have port load_ready, output, 1, word is accepted this cycle if load_valid is also high.
REQ-008 SHALL have port start, input, 1, ends loading and begins streaming.
REQ-009 SHALL have port clear, input, 1, discards contents and returns to loading.
REQ-010 SHALL have port in_pop, input, 1, consumer takes the head word (program "in").
REQ-011 SHALL have port in_data, output, MemoryElementWidth, head word, valid when in_valid is high.
REQ-012 SHALL have port in_valid, output, 1, a word is available to pop.
REQ-013 SHALL have port in_size, output, $clog2(NIn+1), words remaining (program "inSize").
REQ-014 SHALL have port underflow, output, 1, sticky flag: in_pop was seen with no word available.
REQ-015 SHALL have port drained, output, 1, high in state EMPTY.

Function
REQ-016 SHALL implement states LOAD, STREAM and EMPTY, held in one registered state variable.
REQ-017 In LOAD, load_ready SHALL equal (count < NIn), and an accepted word SHALL be written at the tail and increment count.
REQ-018 In LOAD, start SHALL move to STREAM when count > 0, or to EMPTY when count == 0; a load accepted in the same cycle SHALL be counted before this decision.
REQ-019 In STREAM, in_valid SHALL be 1, and in_data SHALL be the head word combinationally (first-word fall-through, zero latency).
REQ-020 In STREAM, in_pop SHALL advance the head and decrement count; the pop that makes count 0 SHALL move to EMPTY on that edge.
REQ-021 Outside STREAM, in_valid SHALL be 0, in_data SHALL be 0, and in_pop SHALL leave count and head unchanged.
REQ-022 An in_pop while in_valid is low SHALL set underflow; underflow SHALL clear only on reset or clear.
REQ-023 in_size SHALL equal count in every state.
REQ-024 Head and tail pointers SHALL wrap modulo NIn.
REQ-025 load_ready SHALL be 0 in STREAM and EMPTY; a load_valid in those states SHALL be ignored.
REQ-026 clear SHALL take priority over every other input in every state, and SHALL set count, head, tail and underflow to 0 and the state to LOAD on the next edge.
REQ-027 start outside LOAD SHALL be ignored.

Reset
REQ-028 Asserting reset SHALL immediately force state LOAD, count 0, head 0, tail 0 and underflow 0, which gives load_ready 1, in_valid 0, in_data 0, in_size 0 and drained 0.
REQ-029 Reset asserted mid-stream SHALL discard all words, and storage contents need not be cleared.

Structure
REQ-030 A shared package in_channel_pkg SHALL hold the state enum (LOAD, STREAM, EMPTY) and the default MemoryElementWidth constant.
REQ-031 Storage and pointers SHALL be a sub-module channel_fifo (a synchronous-write, asynchronous-read circular buffer), with the state machine in in_channel_source.

Verification
REQ-032 Reset, load 33, 22 and 11, then start -> in_size 3 and in_data 33; three pops -> in_data 22 then 11, in_size 2, 1, 0, and drained 1 after the third pop.
REQ-033 With NIn=3, load 1, 2, 3 and then offer 4 -> load_ready 0 on the fourth offer, and after start the sequence is 1, 2, 3 only.
REQ-034 In EMPTY, pulse in_pop -> underflow 1 and in_size stays 0; then clear -> underflow 0, state LOAD and load_ready 1.
REQ-035 With NIn=3: load 5, 6, 7; start; pop twice; clear; load 8, 9, 10; start -> in_data 8, 9, 10 in that order (pointer wrap).
REQ-036 Assert reset while in STREAM with in_size 2 -> in_valid 0 and in_size 0 immediately, without waiting for a clock edge.
REQ-037 Present load_valid with data 44 together with start while count is 0 -> state becomes STREAM, in_size 1 and in_data 44.

Source files
------------

// File: rtl/in_channel_pkg.sv
// rtl/in_channel_pkg.sv - shared types and constants for the input channel source
package in_channel_pkg;

  // Channel lifecycle: fill from the host, stream to the consumer, then sit drained
  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    STREAM = 2'd1,
    EMPTY  = 2'd2
  } state_t;

  localparam int DefaultMemoryElementWidth = 12;

  // Pointer width that stays legal for a single-entry buffer
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/channel_fifo.sv
// rtl/channel_fifo.sv - circular buffer with synchronous write and asynchronous read
module channel_fifo
  import in_channel_pkg::*;
#(
  parameter int Width = DefaultMemoryElementWidth,
  parameter int Depth = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       i_clear,
  input  logic                       i_wr_en,
  input  logic [Width-1:0]           i_wr_data,
  input  logic                       i_rd_en,
  output logic [Width-1:0]           o_rd_data,
  output logic [$clog2(Depth+1)-1:0] o_count
);

  localparam int PtrW = ptr_width(Depth);
  localparam int CntW = $clog2(Depth + 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);

  logic [Width-1:0] r_mem [Depth];
  logic [PtrW-1:0]  r_head;
  logic [PtrW-1:0]  r_tail;
  logic [CntW-1:0]  r_count;

  // Storage is left untouched by reset/clear; only the pointers define validity
  always_ff @(posedge clock) begin
    if (i_wr_en) begin
      r_mem[r_tail] <= i_wr_data;
    end
  end

  // Pointer and occupancy bookkeeping, wrapping modulo Depth
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_wr_en) begin
        r_tail <= (r_tail == LastPtr) ? '0 : r_tail + PtrW'(1);
      end
      if (i_rd_en) begin
        r_head <= (r_head == LastPtr) ? '0 : r_head + PtrW'(1);
      end
      if (i_wr_en && !i_rd_en) begin
        r_count <= r_count + CntW'(1);
      end else if (i_rd_en && !i_wr_en) begin
        r_count <= r_count - CntW'(1);
      end
    end
  end

  assign o_rd_data = r_mem[r_head];
  assign o_count   = r_count;

endmodule

// File: rtl/in_channel_source.sv
// rtl/in_channel_source.sv - host-loaded word channel streamed to a consumer program
module in_channel_source
  import in_channel_pkg::*;
#(
  parameter int MemoryElementWidth = DefaultMemoryElementWidth,
  parameter int NIn = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          load_valid,
  input  logic [MemoryElementWidth-1:0] load_data,
  output logic                          load_ready,
  input  logic                          start,
  input  logic                          clear,
  input  logic                          in_pop,
  output logic [MemoryElementWidth-1:0] in_data,
  output logic                          in_valid,
  output logic [$clog2(NIn+1)-1:0]      in_size,
  output logic                          underflow,
  output logic                          drained
);

  localparam int CntW = $clog2(NIn + 1);

  state_t                        r_state;
  logic                          r_underflow;
  logic [CntW-1:0]               w_count;
  logic [MemoryElementWidth-1:0] w_head_data;
  logic                          w_load_accept;
  logic                          w_pop_accept;

  // Everything the outside sees is a function of the registered state and count,
  // so an asynchronous reset shows up on the outputs without waiting for an edge
  assign load_ready    = (r_state == LOAD) && (w_count < CntW'(NIn));
  assign in_valid      = (r_state == STREAM);
  assign in_data       = in_valid ? w_head_data : '0;
  assign in_size       = w_count;
  assign underflow     = r_underflow;
  assign drained       = (r_state == EMPTY);

  // clear wins over any load or pop offered in the same cycle
  assign w_load_accept = load_ready && load_valid && !clear;
  assign w_pop_accept  = in_valid && in_pop && !clear;

  channel_fifo #(
    .Width (MemoryElementWidth),
    .Depth (NIn)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .i_clear   (clear),
    .i_wr_en   (w_load_accept),
    .i_wr_data (load_data),
    .i_rd_en   (w_pop_accept),
    .o_rd_data (w_head_data),
    .o_count   (w_count)
  );

  // Channel state machine and sticky underflow flag
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= LOAD;
      r_underflow <= 1'b0;
    end else if (clear) begin
      r_state     <= LOAD;
      r_underflow <= 1'b0;
    end else begin
      if (in_pop && !in_valid) begin
        r_underflow <= 1'b1;
      end
      case (r_state)
        LOAD: begin
          // A word accepted alongside start counts toward the stream/empty decision
          if (start) begin
            r_state <= (w_load_accept || (w_count != '0)) ? STREAM : EMPTY;
          end
        end
        STREAM: begin
          if (w_pop_accept && (w_count == CntW'(1))) begin
            r_state <= EMPTY;
          end
        end
        EMPTY: begin
          r_state <= EMPTY;
        end
        default: begin
          r_state <= LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_in_channel_source.sv
// tb/tb_in_channel_source.sv - scoreboard bench for in_channel_source
module tb_in_channel_source;

  localparam int W    = 12;
  localparam int NIN  = 3;
  localparam int SZW  = $clog2(NIN + 1);

  logic           clock = 1'b0;
  logic           reset;
  logic           load_valid;
  logic [W-1:0]   load_data;
  logic           load_ready;
  logic           start;
  logic           clear;
  logic           in_pop;
  logic [W-1:0]   in_data;
  logic           in_valid;
  logic [SZW-1:0] in_size;
  logic           underflow;
  logic           drained;

  logic [W-1:0] sb[$];
  int           m_cnt;
  int           n_vec;
  int           n_miss;

  in_channel_source #(
    .MemoryElementWidth (W),
    .NIn                (NIN)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .start      (start),
    .clear      (clear),
    .in_pop     (in_pop),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_size    (in_size),
    .underflow  (underflow),
    .drained    (drained)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load_word(input logic [W-1:0] d);
    load_valid = 1'b1;
    load_data  = d;
    if (m_cnt < NIN) begin
      sb.push_back(d);
      m_cnt++;
    end
    tick();
    load_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    sb.delete();
    m_cnt = 0;
  endtask

  task automatic pop_word();
    in_pop = 1'b1;
    tick();
    in_pop = 1'b0;
    if (m_cnt > 0) m_cnt--;
  endtask

  task automatic test_reset();
    reset = 1'b1; load_valid = 1'b0; load_data = '0; start = 1'b0;
    clear = 1'b0; in_pop = 1'b0; m_cnt = 0;
    sb.delete();
    tick();
    n_vec++; if (load_ready !== 1'b1) begin n_miss++; $display("FAIL reset_load_ready got %b want 1", load_ready); end
    n_vec++; if (in_valid !== 1'b0) begin n_miss++; $display("FAIL reset_in_valid got %b want 0", in_valid); end
    n_vec++; if (in_data !== '0) begin n_miss++; $display("FAIL reset_in_data got %0d want 0", in_data); end
    n_vec++; if (in_size !== '0) begin n_miss++; $display("FAIL reset_in_size got %0d want 0", in_size); end
    n_vec++; if (drained !== 1'b0) begin n_miss++; $display("FAIL reset_drained got %b want 0", drained); end
    n_vec++; if (underflow !== 1'b0) begin n_miss++; $display("FAIL reset_underflow got %b want 0", underflow); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic_stream();
    logic [W-1:0] exp;
    load_word(12'd33);
    load_word(12'd22);
    load_word(12'd11);
    pulse_start();
    n_vec++; if (in_size !== SZW'(3)) begin n_miss++; $display("FAIL basic_size_after_start got %0d want 3", in_size); end
    n_vec++; if (in_valid !== 1'b1) begin n_miss++; $display("FAIL basic_valid got %b want 1", in_valid); end
    for (int i = 0; i < 3; i++) begin
      exp = sb.pop_front();
      n_vec++; if (in_data !== exp) begin n_miss++; $display("FAIL basic_data[%0d] got %0d want %0d", i, in_data, exp); end
      pop_word();
      n_vec++; if (in_size !== SZW'(m_cnt)) begin n_miss++; $display("FAIL basic_size[%0d] got %0d want %0d", i, in_size, m_cnt); end
    end
    n_vec++; if (drained !== 1'b1) begin n_miss++; $display("FAIL basic_drained got %b want 1", drained); end
    n_vec++; if (in_data !== '0) begin n_miss++; $display("FAIL basic_data_empty got %0d want 0", in_data); end
  endtask

  task automatic test_full();
    logic [W-1:0] exp;
    pulse_clear();
    load_word(12'd1);
    load_word(12'd2);
    load_word(12'd3);
    load_valid = 1'b1;
    load_data  = 12'd4;
    #1;
    n_vec++; if (load_ready !== 1'b0) begin n_miss++; $display("FAIL full_load_ready got %b want 0", load_ready); end
    tick();
    load_valid = 1'b0;
    n_vec++; if (in_size !== SZW'(3)) begin n_miss++; $display("FAIL full_size got %0d want 3", in_size); end
    pulse_start();
    // a load offered while streaming must be refused and ignored
    load_valid = 1'b1;
    load_data  = 12'd99;
    #1;
    n_vec++; if (load_ready !== 1'b0) begin n_miss++; $display("FAIL stream_load_ready got %b want 0", load_ready); end
    tick();
    load_valid = 1'b0;
    while (sb.size() > 0) begin
      exp = sb.pop_front();
      n_vec++; if (in_data !== exp) begin n_miss++; $display("FAIL full_data got %0d want %0d", in_data, exp); end
      pop_word();
    end
    n_vec++; if (drained !== 1'b1) begin n_miss++; $display("FAIL full_drained got %b want 1", drained); end
    n_vec++; if (in_valid !== 1'b0) begin n_miss++; $display("FAIL full_valid_after got %b want 0", in_valid); end
  endtask

  task automatic test_underflow();
    pop_word();
    n_vec++; if (underflow !== 1'b1) begin n_miss++; $display("FAIL uf_set got %b want 1", underflow); end
    n_vec++; if (in_size !== '0) begin n_miss++; $display("FAIL uf_size got %0d want 0", in_size); end
    pulse_start();
    n_vec++; if (drained !== 1'b1) begin n_miss++; $display("FAIL uf_start_ignored got %b want 1", drained); end
    n_vec++; if (underflow !== 1'b1) begin n_miss++; $display("FAIL uf_sticky got %b want 1", underflow); end
    pulse_clear();
    n_vec++; if (underflow !== 1'b0) begin n_miss++; $display("FAIL uf_clear got %b want 0", underflow); end
    n_vec++; if (load_ready !== 1'b1) begin n_miss++; $display("FAIL uf_clear_ready got %b want 1", load_ready); end
    n_vec++; if (drained !== 1'b0) begin n_miss++; $display("FAIL uf_clear_drained got %b want 0", drained); end
  endtask

  task automatic test_wrap();
    logic [W-1:0] exp;
    load_word(12'd5);
    load_word(12'd6);
    load_word(12'd7);
    pulse_start();
    for (int i = 0; i < 2; i++) begin
      exp = sb.pop_front();
      n_vec++; if (in_data !== exp) begin n_miss++; $display("FAIL wrap_pre[%0d] got %0d want %0d", i, in_data, exp); end
      pop_word();
    end
    pulse_clear();
    load_word(12'd8);
    load_word(12'd9);
    load_word(12'd10);
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      exp = sb.pop_front();
      n_vec++; if (in_data !== exp) begin n_miss++; $display("FAIL wrap_post[%0d] got %0d want %0d", i, in_data, exp); end
      pop_word();
    end
    n_vec++; if (drained !== 1'b1) begin n_miss++; $display("FAIL wrap_drained got %b want 1", drained); end
  endtask

  task automatic test_reset_midstream();
    pulse_clear();
    load_word(12'd100);
    load_word(12'd200);
    pulse_start();
    n_vec++; if (in_size !== SZW'(2)) begin n_miss++; $display("FAIL mid_size_before got %0d want 2", in_size); end
    reset = 1'b1;
    #2;
    n_vec++; if (in_valid !== 1'b0) begin n_miss++; $display("FAIL mid_valid got %b want 0", in_valid); end
    n_vec++; if (in_size !== '0) begin n_miss++; $display("FAIL mid_size got %0d want 0", in_size); end
    n_vec++; if (load_ready !== 1'b1) begin n_miss++; $display("FAIL mid_ready got %b want 1", load_ready); end
    tick();
    reset = 1'b0;
    sb.delete();
    m_cnt = 0;
    tick();
  endtask

  task automatic test_load_with_start();
    logic [W-1:0] exp;
    load_valid = 1'b1;
    load_data  = 12'd44;
    start      = 1'b1;
    sb.push_back(12'd44);
    m_cnt++;
    tick();
    load_valid = 1'b0;
    start      = 1'b0;
    n_vec++; if (in_valid !== 1'b1) begin n_miss++; $display("FAIL ls_valid got %b want 1", in_valid); end
    n_vec++; if (in_size !== SZW'(1)) begin n_miss++; $display("FAIL ls_size got %0d want 1", in_size); end
    exp = sb.pop_front();
    n_vec++; if (in_data !== exp) begin n_miss++; $display("FAIL ls_data got %0d want %0d", in_data, exp); end
    // clear outranks a pop in the same cycle
    in_pop = 1'b1;
    clear  = 1'b1;
    tick();
    in_pop = 1'b0;
    clear  = 1'b0;
    m_cnt  = 0;
    n_vec++; if (underflow !== 1'b0) begin n_miss++; $display("FAIL ls_clear_uf got %b want 0", underflow); end
    n_vec++; if (load_ready !== 1'b1) begin n_miss++; $display("FAIL ls_clear_ready got %b want 1", load_ready); end
    // start with nothing loaded goes straight to drained
    pulse_start();
    n_vec++; if (drained !== 1'b1) begin n_miss++; $display("FAIL empty_start got %b want 1", drained); end
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    test_reset();
    test_basic_stream();
    test_full();
    test_underflow();
    test_wrap();
    test_reset_midstream();
    test_load_with_start();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
